regfile_mp: RTL and testbench

- Parametrised multi-port register file, successor to the 16x16 two-read/one-write file.
- Configurable data width, register count and read-port count; two write ports (execute and load writeback).
- Per-register busy scoreboard for the pipelined core.
- Register 0 is hardwired zero. Reads are synchronous, with optional write-to-read bypass.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_read_port.sv | 60 ++++++
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Provides default sizes, the zero-register index and the select-width function.
package regfile_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 16;
  localparam int ZERO_REG     = 0;

  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One synchronous read port: select mux, zero check, optional bypass, hold register.
// Ports: i_clk, i_reset, i_hold, i_sel, i_regs (flat storage), i_busy, o_data, o_busy.
// Macro REGFILE_BYPASS_EN adds same-edge write forwarding (w0/w1 inputs).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SEL_W    = sel_w(NUM_REGS)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_hold,
  input  logic [SEL_W-1:0]           i_sel,
  input  logic [NUM_REGS*DATA_W-1:0] i_regs,
  input  logic [NUM_REGS-1:0]        i_busy,
`ifdef REGFILE_BYPASS_EN
  input  logic                       i_w0_acc,
  input  logic [SEL_W-1:0]           i_w0_sel,
  input  logic [DATA_W-1:0]          i_w0_data,
  input  logic                       i_w1_acc,
  input  logic [SEL_W-1:0]           i_w1_sel,
  input  logic [DATA_W-1:0]          i_w1_data,
`endif
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_busy
);

  localparam logic [SEL_W-1:0] ZSEL = SEL_W'(ZERO_REG);

  logic [DATA_W-1:0] data_d;
  logic              busy_d;

  always_comb begin
    data_d = i_regs[i_sel*DATA_W +: DATA_W];
    busy_d = i_busy[i_sel];
`ifdef REGFILE_BYPASS_EN
    // w0 is already suppressed on a collision, so w1 naturally wins
    if (i_w0_acc && i_w0_sel == i_sel)
      data_d = i_w0_data;
    if (i_w1_acc && i_w1_sel == i_sel)
      data_d = i_w1_data;
`endif
    if (i_sel == ZSEL) begin
      data_d = '0;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data <= '0;
      o_busy <= 1'b0;
    end else if (!i_hold) begin
      o_data <= data_d;
      o_busy <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD sync read ports, two write ports, busy scoreboard.
// Ports: i_clk, i_reset, i_rd_hold, i_rd_sel, o_rd_data, o_rd_busy, i_w0_*, i_w1_*,
// i_rsv_en/i_rsv_sel, o_busy_vec. Macro REGFILE_BYPASS_EN enables write-to-read bypass.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int SEL_W    = sel_w(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_rd_hold,
  input  logic [NUM_RD*SEL_W-1:0]  i_rd_sel,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_w0_en,
  input  logic [SEL_W-1:0]         i_w0_sel,
  input  logic [DATA_W-1:0]        i_w0_data,
  input  logic                     i_w1_en,
  input  logic [SEL_W-1:0]         i_w1_sel,
  input  logic [DATA_W-1:0]        i_w1_data,
  input  logic                     i_rsv_en,
  input  logic [SEL_W-1:0]         i_rsv_sel,
  output logic [NUM_REGS-1:0]      o_busy_vec
);

  localparam logic [SEL_W-1:0] ZSEL = SEL_W'(ZERO_REG);

  logic [DATA_W-1:0]          regs_q [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [NUM_REGS-1:0]        busy_q;
  logic [NUM_REGS-1:0]        busy_d;
  logic [NUM_REGS-1:0]        rd_busy_src;
  logic                       w0_acc;
  logic                       w1_acc;

  assign w1_acc = i_w1_en && (i_w1_sel != ZSEL);
  // w1 has priority when both target the same register
  assign w0_acc = i_w0_en && (i_w0_sel != ZSEL)
                  && !(w1_acc && (i_w1_sel == i_w0_sel));

  // a reserve in the same cycle as a write wins: new producer in flight
  always_comb begin
    busy_d = busy_q;
    if (w0_acc)
      busy_d[i_w0_sel] = 1'b0;
    if (w1_acc)
      busy_d[i_w1_sel] = 1'b0;
    if (i_rsv_en && (i_rsv_sel != ZSEL))
      busy_d[i_rsv_sel] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      busy_q <= '0;
      for (int r = 0; r < NUM_REGS; r++)
        regs_q[r] <= '0;
    end else begin
      busy_q <= busy_d;
      if (w0_acc)
        regs_q[i_w0_sel] <= i_w0_data;
      if (w1_acc)
        regs_q[i_w1_sel] <= i_w1_data;
    end
  end

  assign o_busy_vec = busy_q;

`ifdef REGFILE_BYPASS_EN
  assign rd_busy_src = busy_d;
`else
  assign rd_busy_src = busy_q;
`endif

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
    assign regs_flat[r*DATA_W +: DATA_W] = regs_q[r];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .SEL_W    (SEL_W)
    ) u_rd (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_hold    (i_rd_hold),
      .i_sel     (i_rd_sel[k*SEL_W +: SEL_W]),
      .i_regs    (regs_flat),
      .i_busy    (rd_busy_src),
`ifdef REGFILE_BYPASS_EN
      .i_w0_acc  (w0_acc),
      .i_w0_sel  (i_w0_sel),
      .i_w0_data (i_w0_data),
      .i_w1_acc  (w1_acc),
      .i_w1_sel  (i_w1_sel),
      .i_w1_data (i_w1_data),
`endif
      .o_data    (o_rd_data[k*DATA_W +: DATA_W]),
      .o_busy    (o_rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (16x16, two read ports).
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [7:0]  rd_sel;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        w0_en;
  logic [3:0]  w0_sel;
  logic [15:0] w0_data;
  logic        w1_en;
  logic [3:0]  w1_sel;
  logic [15:0] w1_data;
  logic        rsv_en;
  logic [3:0]  rsv_sel;
  logic [15:0] busy_vec;

  int checks = 0;
  int failures = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // behavioural model
  logic [15:0] m_reg [16];
  logic [15:0] m_busy;
  logic [15:0] m_rd [2];
  logic        m_rb [2];

  regfile_mp #(
    .DATA_W   (16),
    .NUM_REGS (16),
    .NUM_RD   (2)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_rd_hold  (hold),
    .i_rd_sel   (rd_sel),
    .o_rd_data  (rd_data),
    .o_rd_busy  (rd_busy),
    .i_w0_en    (w0_en),
    .i_w0_sel   (w0_sel),
    .i_w0_data  (w0_data),
    .i_w1_en    (w1_en),
    .i_w1_sel   (w1_sel),
    .i_w1_data  (w1_data),
    .i_rsv_en   (rsv_en),
    .i_rsv_sel  (rsv_sel),
    .o_busy_vec (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic idle();
    reset = 0; hold = 0;
    w0_en = 0; w1_en = 0; rsv_en = 0;
  endtask

  // advance one clock; model applies the write/reserve/read rules
  task automatic tick();
    logic [15:0] nr [16];
    logic [15:0] nb;
    logic [15:0] nrd [2];
    logic        nrb [2];
    logic [3:0]  s;
    nr = m_reg; nb = m_busy; nrd = m_rd; nrb = m_rb;
    if (reset) begin
      for (int r = 0; r < 16; r++) nr[r] = '0;
      nb = '0;
      for (int k = 0; k < 2; k++) begin
        nrd[k] = '0; nrb[k] = 1'b0;
      end
    end else begin
      if (w0_en && w0_sel != 0) begin
        nr[w0_sel] = w0_data; nb[w0_sel] = 1'b0;
      end
      if (w1_en && w1_sel != 0) begin
        nr[w1_sel] = w1_data; nb[w1_sel] = 1'b0;
      end
      if (rsv_en && rsv_sel != 0) nb[rsv_sel] = 1'b1;
      if (!hold) begin
        for (int k = 0; k < 2; k++) begin
          s = rd_sel[k*4 +: 4];
          if (s == 0) begin
            nrd[k] = '0; nrb[k] = 1'b0;
          end else if (BYPASS) begin
            nrd[k] = nr[s]; nrb[k] = nb[s];
          end else begin
            nrd[k] = m_reg[s]; nrb[k] = m_busy[s];
          end
        end
      end
    end
    @(posedge clk);
    #1;
    m_reg = nr; m_busy = nb; m_rd = nrd; m_rb = nrb;
  endtask

  task automatic test_reset();
    idle();
    reset = 1; rd_sel = 8'h00;
    tick();
    reset = 0;
    checks++;
    if (rd_data !== 32'h0 || rd_busy !== 2'b0 || busy_vec !== 16'h0) begin
      failures++;
      $display("FAIL reset_state got data=%h busy=%b vec=%h want 0", rd_data, rd_busy, busy_vec);
    end
    for (int r = 0; r < 16; r++) begin
      rd_sel = {4'(r), 4'(r)};
      tick();
      checks++;
      if (rd_data !== 32'h0 || rd_busy !== 2'b0) begin
        failures++;
        $display("FAIL reset_read r%0d got data=%h busy=%b want 0", r, rd_data, rd_busy);
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    w0_en = 1; w0_sel = 3; w0_data = 16'hBEEF;
    tick();
    w0_en = 0; rd_sel = 8'h03;
    tick();
    checks++;
    if (rd_data[15:0] !== 16'hBEEF) begin
      failures++;
      $display("FAIL write_read got %h want beef", rd_data[15:0]);
    end
    w0_en = 1; w0_sel = 0; w0_data = 16'h1234;
    tick();
    w0_en = 0; rd_sel = 8'h00;
    tick();
    checks++;
    if (rd_data !== 32'h0 || rd_busy !== 2'b0) begin
      failures++;
      $display("FAIL reg0_write got %h want 0", rd_data);
    end
  endtask

  task automatic test_collision();
    idle();
    w0_en = 1; w0_sel = 5; w0_data = 16'h1111;
    w1_en = 1; w1_sel = 5; w1_data = 16'h2222;
    tick();
    idle();
    rd_sel = 8'h50;
    tick();
    checks++;
    if (rd_data[31:16] !== 16'h2222) begin
      failures++;
      $display("FAIL collision got %h want 2222", rd_data[31:16]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en = 1; rsv_sel = 7;
    tick();
    rsv_en = 0;
    checks++;
    if (busy_vec !== 16'h0080) begin
      failures++;
      $display("FAIL rsv_vec got %h want 0080", busy_vec);
    end
    rd_sel = 8'h07;
    tick();
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL rsv_read_busy got %b want 1", rd_busy[0]);
    end
    w0_en = 1; w0_sel = 7; w0_data = 16'h0055;
    tick();
    w0_en = 0;
    checks++;
    if (busy_vec[7] !== 1'b0) begin
      failures++;
      $display("FAIL write_clears got %b want 0", busy_vec[7]);
    end
    w0_en = 1; w0_sel = 7; w0_data = 16'h00AA;
    rsv_en = 1; rsv_sel = 7;
    tick();
    idle();
    checks++;
    if (busy_vec[7] !== 1'b1) begin
      failures++;
      $display("FAIL rsv_wr_busy got %b want 1", busy_vec[7]);
    end
    tick();
    checks++;
    if (rd_data[15:0] !== 16'h00AA || rd_busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL rsv_wr_data got %h/%b want 00aa/1", rd_data[15:0], rd_busy[0]);
    end
  endtask

  task automatic test_bypass();
    idle();
    w0_en = 1; w0_sel = 2; w0_data = 16'h1357;
    tick();
    w0_data = 16'h5A5A; rd_sel = 8'h02;
    tick();
    w0_en = 0;
    checks++;
    if (rd_data[15:0] !== (BYPASS ? 16'h5A5A : 16'h1357)) begin
      failures++;
      $display("FAIL bypass got %h want %h", rd_data[15:0], BYPASS ? 16'h5A5A : 16'h1357);
    end
    tick();
    checks++;
    if (rd_data[15:0] !== 16'h5A5A) begin
      failures++;
      $display("FAIL bypass_next got %h want 5a5a", rd_data[15:0]);
    end
  endtask

  task automatic test_hold();
    idle();
    hold = 1;
    w0_en = 1; w0_sel = 2; w0_data = 16'h0F0F;
    rsv_en = 1; rsv_sel = 9;
    tick();
    w0_en = 0; rsv_en = 0;
    tick();
    checks++;
    if (rd_data[15:0] !== 16'h5A5A || busy_vec[9] !== 1'b1) begin
      failures++;
      $display("FAIL hold got %h vec9=%b want 5a5a/1", rd_data[15:0], busy_vec[9]);
    end
    hold = 0;
    tick();
    checks++;
    if (rd_data[15:0] !== 16'h0F0F) begin
      failures++;
      $display("FAIL hold_release got %h want 0f0f", rd_data[15:0]);
    end
  endtask

  task automatic test_mid_reset();
    idle();
    w0_en = 1; w0_sel = 4; w0_data = 16'h4444;
    rsv_en = 1; rsv_sel = 6; rd_sel = 8'h34;
    tick();
    reset = 1;
    w0_data = 16'hDEAD; rsv_sel = 8;
    tick();
    idle();
    checks++;
    if (busy_vec !== 16'h0 || rd_data !== 32'h0 || rd_busy !== 2'b0) begin
      failures++;
      $display("FAIL mid_reset got vec=%h data=%h busy=%b want 0", busy_vec, rd_data, rd_busy);
    end
    rd_sel = 8'h84;
    tick();
    checks++;
    if (rd_data !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_wr got %h want 0", rd_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(49) == 0);
      hold    = ($urandom_range(7) == 0);
      rd_sel  = 8'($urandom);
      w0_en   = 1'($urandom);
      w0_sel  = 4'($urandom);
      w0_data = 16'($urandom);
      w1_en   = 1'($urandom);
      w1_sel  = ($urandom_range(3) == 0) ? w0_sel : 4'($urandom);
      w1_data = 16'($urandom);
      rsv_en  = 1'($urandom);
      rsv_sel = ($urandom_range(3) == 0) ? w0_sel : 4'($urandom);
      tick();
      checks++;
      if (rd_data !== {m_rd[1], m_rd[0]} || rd_busy !== {m_rb[1], m_rb[0]}
          || busy_vec !== m_busy) begin
        failures++;
        $display("FAIL random[%0d] got %h/%b/%h want %h/%b/%h", i, rd_data, rd_busy,
                 busy_vec, {m_rd[1], m_rd[0]}, {m_rb[1], m_rb[0]}, m_busy);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rd_sel = 8'h00;
    w0_sel = 0; w0_data = 0; w1_sel = 0; w1_data = 0; rsv_sel = 0;
    for (int r = 0; r < 16; r++) m_reg[r] = 'x;
    m_busy = 'x;
    m_rd[0] = 'x; m_rd[1] = 'x; m_rb[0] = 1'bx; m_rb[1] = 1'bx;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_hold();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
